// File: rtl/mario_motion_pkg.sv
// Shared types and constants for Mario's motion control: jump sequencer states,
// USB HID key codes and the default jump profile length.
package mario_motion_pkg;

    typedef enum logic [2:0] {
        GROUND = 3'd0,
        LAUNCH = 3'd1,
        RISE   = 3'd2,
        FALL   = 3'd3,
        LAND   = 3'd4
    } jump_state_e;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int JUMP_FRAMES_DEF = 40;

    // True when any of the four packed keycode bytes equals code.
    function automatic logic key_match(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = hit | (kc[8*i +: 8] == code);
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Decodes one key from the packed USB keycode word and flags its rising edge.
// Reusable for jump, left, right and fire keys.
module key_edge_detect
    import mario_motion_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] keycode_i,
    input  logic [7:0]  key_code_i,
    output logic        key_now_o,
    output logic        key_rise_o
);

    logic key_prev_q;

    assign key_now_o  = key_match(keycode_i, key_code_i);
    assign key_rise_o = key_now_o & ~key_prev_q;

    // Remember last frame's key state for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_now_o;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Vertical motion sequencer: launches the jump profile and muxes rise/fall/ground
// y velocity. Optional macro VARIABLE_JUMP_EN enables short hops on key release.
module jump_ctrl
    import mario_motion_pkg::*;
#(
    parameter logic [7:0] JUMP_KEY    = KEY_W,
    parameter int          JUMP_FRAMES = JUMP_FRAMES_DEF,
    parameter int          GRAV_DIV    = 4,
    parameter int          MAX_FALL    = 4,
    parameter int          COOLDOWN    = 2
) (
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [31:0] keycode,
    input  logic        on_ground,
    input  logic        hit_ceiling,
    input  logic [9:0]  jump_y_motion,
    output logic        jump_en,
    output logic [9:0]  y_motion,
    output logic        airborne
);

    localparam logic [5:0] GUARD_LOAD = 6'(JUMP_FRAMES);
    localparam logic [5:0] RISE_LAST  = 6'(JUMP_FRAMES - 1);
    localparam logic [3:0] DIV_LAST   = 4'(GRAV_DIV - 1);
    localparam logic [9:0] FALL_MAX   = 10'(MAX_FALL);
    localparam logic [3:0] COOL_LOAD  = 4'(COOLDOWN);

    jump_state_e state_q, state_d;
    logic [5:0]  guard_q, guard_d;
    logic [3:0]  cool_q, cool_d;
    logic [5:0]  rise_cnt_q, rise_cnt_d;
    logic [9:0]  fall_vel_q, fall_vel_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic        jump_en_q;
    logic        airborne_q;

    logic key_now_s;
    logic key_rise_s;
    logic release_s;
    logic short_hop_s;
    logic rise_exit_s;

    key_edge_detect u_key (
        .clk_i      (frame_clk),
        .rst_i      (Reset),
        .keycode_i  (keycode),
        .key_code_i (JUMP_KEY),
        .key_now_o  (key_now_s),
        .key_rise_o (key_rise_s)
    );

    assign release_s = ~key_now_s & (rise_cnt_q != 6'd0);
`ifdef VARIABLE_JUMP_EN
    assign short_hop_s = release_s;
`else
    // Key state is ignored once launched; every jump runs to apex, ceiling or timeout.
    assign short_hop_s = release_s & 1'b0;
`endif

    assign rise_exit_s = hit_ceiling
                       | ((rise_cnt_q != 6'd0) & ~jump_y_motion[9])
                       | (rise_cnt_q == RISE_LAST)
                       | short_hop_s;

    // Next-state and counter update logic.
    always_comb begin
        state_d    = state_q;
        cool_d     = cool_q;
        rise_cnt_d = rise_cnt_q;
        fall_vel_d = fall_vel_q;
        div_cnt_d  = div_cnt_q;
        if (guard_q != 6'd0) begin
            guard_d = guard_q - 6'd1;
        end else begin
            guard_d = guard_q;
        end

        case (state_q)
            GROUND: begin
                if (cool_q != 4'd0) begin
                    cool_d = cool_q - 4'd1;
                end else begin
                    cool_d = cool_q;
                end
                if (!on_ground) begin
                    state_d    = FALL;
                    fall_vel_d = 10'd0;
                    div_cnt_d  = 4'd0;
                end else if (key_rise_s && (guard_q == 6'd0) && (cool_q == 4'd0)) begin
                    state_d = LAUNCH;
                end else begin
                    state_d = GROUND;
                end
            end
            LAUNCH: begin
                state_d    = RISE;
                rise_cnt_d = 6'd0;
                guard_d    = GUARD_LOAD;
            end
            RISE: begin
                rise_cnt_d = rise_cnt_q + 6'd1;
                if (rise_exit_s) begin
                    state_d    = FALL;
                    fall_vel_d = 10'd0;
                    div_cnt_d  = 4'd0;
                end else begin
                    state_d = RISE;
                end
            end
            FALL: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 4'd0;
                    if (fall_vel_q < FALL_MAX) begin
                        fall_vel_d = fall_vel_q + 10'd1;
                    end else begin
                        fall_vel_d = fall_vel_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
                if (on_ground) begin
                    state_d = LAND;
                end else begin
                    state_d = FALL;
                end
            end
            LAND: begin
                cool_d  = COOL_LOAD;
                state_d = GROUND;
            end
            default: begin
                state_d = GROUND;
            end
        endcase
    end

    // Sequencer state, counters and registered launch/airborne flags.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= GROUND;
            guard_q    <= 6'd0;
            cool_q     <= 4'd0;
            rise_cnt_q <= 6'd0;
            fall_vel_q <= 10'd0;
            div_cnt_q  <= 4'd0;
            jump_en_q  <= 1'b0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            cool_q     <= cool_d;
            rise_cnt_q <= rise_cnt_d;
            fall_vel_q <= fall_vel_d;
            div_cnt_q  <= div_cnt_d;
            jump_en_q  <= (state_d == LAUNCH);
            airborne_q <= (state_d == LAUNCH) || (state_d == RISE) || (state_d == FALL);
        end
    end

    // Final y velocity: profile while rising, gravity while falling, else still.
    always_comb begin
        y_motion = 10'd0;
        case (state_q)
            RISE:    y_motion = jump_y_motion;
            FALL:    y_motion = fall_vel_q;
            default: y_motion = 10'd0;
        endcase
    end

    assign jump_en  = jump_en_q;
    assign airborne = airborne_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed, table-driven bench for jump_ctrl with hand-written multi-frame corner cases.
module tb_jump_ctrl;

    logic        Reset;
    logic        frame_clk;
    logic [31:0] keycode;
    logic        on_ground;
    logic        hit_ceiling;
    logic [9:0]  jump_y_motion;
    logic        jump_en;
    logic [9:0]  y_motion;
    logic        airborne;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] K1 = 32'h0000_1A00;
    localparam logic [31:0] K0 = 32'h0000_001A;
    localparam logic [31:0] K3 = 32'h1A00_0000;
    localparam logic [9:0]  UP = 10'h3FE;

    typedef struct {
        logic [31:0] kc;
        logic        og;
        logic        hc;
        logic [9:0]  jym;
        logic        en;
        logic [9:0]  y;
        logic        air;
    } vec_t;

    vec_t tbl[55];

    jump_ctrl dut (
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .on_ground     (on_ground),
        .hit_ceiling   (hit_ceiling),
        .jump_y_motion (jump_y_motion),
        .jump_en       (jump_en),
        .y_motion      (y_motion),
        .airborne      (airborne)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] kc, input logic og, input logic hc, input logic [9:0] jym);
        keycode       = kc;
        on_ground     = og;
        hit_ceiling   = hc;
        jump_y_motion = jym;
        #1;
    endtask

    task automatic adv();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(32'h0, 1'b1, 1'b0, 10'h0);
        adv();
        chk("rst_jump_en", {31'h0, jump_en}, 32'h0);
        chk("rst_y_motion", {22'h0, y_motion}, 32'h0);
        chk("rst_airborne", {31'h0, airborne}, 32'h0);
        adv();
        Reset = 1'b0;
    endtask

    initial begin
        int sum;
        int n;
        int bad;

        // Main jump: press at frame 3, -2 px for 15 frames, apex at 20, fall and land,
        // key held through landing, then release and re-press for a second launch.
        for (int f = 0; f < 55; f++) begin
            tbl[f].kc  = (f < 3 || f == 51) ? 32'h0 : K1;
            tbl[f].og  = (f >= 21 && f <= 42) ? 1'b0 : 1'b1;
            tbl[f].hc  = 1'b0;
            tbl[f].jym = ((f >= 5 && f <= 19) || f == 54) ? UP : 10'h0;
            tbl[f].en  = (f == 4 || f == 53);
            tbl[f].air = (f >= 4 && f <= 43) || (f >= 53);
            if ((f >= 5 && f <= 19) || f == 54) tbl[f].y = UP;
            else if (f >= 21 && f <= 24) tbl[f].y = 10'd0;
            else if (f >= 25 && f <= 28) tbl[f].y = 10'd1;
            else if (f >= 29 && f <= 32) tbl[f].y = 10'd2;
            else if (f >= 33 && f <= 36) tbl[f].y = 10'd3;
            else if (f >= 37 && f <= 43) tbl[f].y = 10'd4;
            else tbl[f].y = 10'd0;
        end

        do_reset();
        for (int f = 0; f < 55; f++) begin
            drive(tbl[f].kc, tbl[f].og, tbl[f].hc, tbl[f].jym);
            if (jump_en !== tbl[f].en || y_motion !== tbl[f].y || airborne !== tbl[f].air) begin
                $display("FAIL tbl_frame_%0d: got en=%0b y=%0h air=%0b expected en=%0b y=%0h air=%0b",
                         f, jump_en, y_motion, airborne, tbl[f].en, tbl[f].y, tbl[f].air);
                errors++;
            end
            checks++;
            adv();
        end

        // Asynchronous reset mid-RISE clears outputs without a clock edge.
        drive(K1, 1'b1, 1'b0, UP);
        chk("pre_reset_rise_y", {22'h0, y_motion}, {22'h0, UP});
        Reset = 1'b1;
        #1;
        chk("async_rst_y", {22'h0, y_motion}, 32'h0);
        chk("async_rst_en", {31'h0, jump_en}, 32'h0);
        chk("async_rst_air", {31'h0, airborne}, 32'h0);

        // Ceiling at rise frame 5: 10 px total rise, then FALL with y=0.
        do_reset();
        drive(K0, 1'b1, 1'b0, 10'h0);
        chk("b_idle_en", {31'h0, jump_en}, 32'h0);
        adv();
        drive(K0, 1'b1, 1'b0, 10'h0);
        chk("b_launch_en", {31'h0, jump_en}, 32'h1);
        adv();
        sum = 0;
        for (int i = 1; i <= 5; i++) begin
            drive(K0, 1'b1, (i == 5), UP);
            sum += int'($signed(y_motion));
            adv();
        end
        chk("b_rise_total", sum, -10);
        drive(32'h0, 1'b0, 1'b0, UP);
        chk("b_ceil_fall_y", {22'h0, y_motion}, 32'h0);
        chk("b_ceil_fall_air", {31'h0, airborne}, 32'h1);
        adv();
        drive(32'h0, 1'b0, 1'b0, 10'h0);
        adv();
        drive(32'h0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(32'h0, 1'b1, 1'b0, 10'h0);
        chk("c_land_air", {31'h0, airborne}, 32'h0);
        adv();
        adv();
        adv();
        // Cooldown has expired here, but the retrigger guard is still running.
        drive(K0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K0, 1'b1, 1'b0, 10'h0);
        chk("c_guard_block_en", {31'h0, jump_en}, 32'h0);
        chk("c_guard_block_air", {31'h0, airborne}, 32'h0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            adv();
            drive(K0, 1'b1, 1'b0, 10'h0);
            if (jump_en !== 1'b0) bad++;
        end
        chk("c_edge_not_queued", bad, 0);
        adv();
        drive(32'h0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K0, 1'b1, 1'b0, 10'h0);
        chk("c_relaunch_en", {31'h0, jump_en}, 32'h1);

        // Walking off a ledge with no key: FALL, airborne, never a launch.
        do_reset();
        drive(32'h0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(32'h0, 1'b0, 1'b0, 10'h0);
        adv();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h0, 1'b0, 1'b0, 10'h0);
            if (jump_en !== 1'b0) bad++;
            if (i == 0) begin
                chk("d_ledge_air", {31'h0, airborne}, 32'h1);
                chk("d_ledge_y0", {22'h0, y_motion}, 32'h0);
            end
            if (i == 4) chk("d_ledge_y1", {22'h0, y_motion}, 32'h1);
            adv();
        end
        chk("d_ledge_no_en", bad, 0);

        // Other keys do not jump; jump key in byte 3 does; timeout after 40 rise frames.
        do_reset();
        drive(32'h0004_0700, 1'b1, 1'b0, 10'h0);
        adv();
        drive(32'h0004_0700, 1'b1, 1'b0, 10'h0);
        chk("e_other_keys_en", {31'h0, jump_en}, 32'h0);
        adv();
        drive(K3, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K3, 1'b1, 1'b0, 10'h0);
        chk("e_byte3_launch", {31'h0, jump_en}, 32'h1);
        adv();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            drive(K3, 1'b1, 1'b0, UP);
            if (y_motion !== UP) break;
            n++;
            adv();
        end
        chk("f_timeout_rise_frames", n, 40);
        chk("f_timeout_fall_y", {22'h0, y_motion}, 32'h0);
        chk("f_timeout_fall_air", {31'h0, airborne}, 32'h1);

        // Key released at rise frame 3.
        do_reset();
        drive(K0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K0, 1'b1, 1'b0, 10'h0);
        adv();
        drive(K0, 1'b1, 1'b0, UP);
        adv();
        drive(K0, 1'b1, 1'b0, UP);
        adv();
        drive(32'h0, 1'b1, 1'b0, UP);
        chk("g_rise3_y", {22'h0, y_motion}, {22'h0, UP});
        adv();
        drive(32'h0, 1'b1, 1'b0, UP);
`ifdef VARIABLE_JUMP_EN
        chk("g_short_hop_y", {22'h0, y_motion}, 32'h0);
`else
        chk("g_full_hop_y", {22'h0, y_motion}, {22'h0, UP});
`endif
        chk("g_hop_air", {31'h0, airborne}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
